// File: rtl/truth_sweep_ctrl.sv
// rtl/truth_sweep_ctrl.sv - truth-table sweep sequencer for a small combinational function
// Optional self-check against a reference table is built only with `define SWEEP_CHECK_EN.
module truth_sweep_ctrl #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                f_in,
`ifdef SWEEP_CHECK_EN
  input  logic [(1<<N)-1:0]   expected,
  output logic                mismatch,
`endif
  output logic [N-1:0]        sel_out,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   table_out
);

  localparam int TW = 1 << N;
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sel_q,   sel_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic [TW-1:0]   table_q, table_d;
`ifdef SWEEP_CHECK_EN
  logic [TW-1:0]   exp_q,   exp_d;
  logic            mm_q,    mm_d;
`endif

  // Next-state and registered-output computation for the sweep sequencer
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
`ifdef SWEEP_CHECK_EN
    exp_d   = exp_q;
    mm_d    = mm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          sel_d   = '0;
          cnt_d   = '0;
          table_d = '0;
`ifdef SWEEP_CHECK_EN
          exp_d   = expected;
          mm_d    = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Last edge of the settle window: capture this vector's result
          table_d[sel_q] = f_in;
          cnt_d          = '0;
          if (&sel_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sel_d   = '0;
`ifdef SWEEP_CHECK_EN
            // Compare the completed table, including the bit captured now
            mm_d    = (table_d != exp_q);
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with immediate abort on reset; partial table is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
`ifdef SWEEP_CHECK_EN
      exp_q   <= '0;
      mm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
`ifdef SWEEP_CHECK_EN
      exp_q   <= exp_d;
      mm_q    <= mm_d;
`endif
    end
  end

  assign sel_out   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
`ifdef SWEEP_CHECK_EN
  assign mismatch  = mm_q;
`endif

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// tb/tb_truth_sweep_ctrl.sv - directed-vector bench for truth_sweep_ctrl
module tb_truth_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       f_in;
  logic [2:0] sel_out;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
`ifdef SWEEP_CHECK_EN
  logic [7:0] exp_in;
  logic       mismatch;
`endif

  int n_vec;
  int n_err;
  int f_mode;

  truth_sweep_ctrl #(.N(3), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .f_in      (f_in),
`ifdef SWEEP_CHECK_EN
    .expected  (exp_in),
    .mismatch  (mismatch),
`endif
    .sel_out   (sel_out),
    .busy      (busy),
    .done      (done),
    .table_out (table_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test: f = (~a&~b) | (b&c) | (a&~b), a = sel_out[2]
  always_comb begin
    case (f_mode)
      1:       f_in = 1'b0;
      2:       f_in = 1'b1;
      default: f_in = (~sel_out[2] & ~sel_out[1]) | (sel_out[1] & sel_out[0]) |
                      (sel_out[2] & ~sel_out[1]);
    endcase
  end

  task automatic do_sweep(input string name, input logic [7:0] exp_tab,
                          input int restart_at, input bit keep_start);
    logic [4:0] exp_st;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      if (c == restart_at) start = 1'b1;
      else if (!keep_start) start = 1'b0;
      exp_st = {1'b1, 1'b0, 3'((c - 1) / 2)};
      n_vec++;
      if ({busy, done, sel_out} !== exp_st) begin
        n_err++;
        $display("FAIL %s cycle %0d: busy/done/sel got %b want %b", name, c,
                 {busy, done, sel_out}, exp_st);
      end
`ifdef SWEEP_CHECK_EN
      if (c == 1) begin
        n_vec++;
        if (mismatch !== 1'b0) begin
          n_err++;
          $display("FAIL %s mismatch_clear: got %b want 0", name, mismatch);
        end
      end
`endif
      @(negedge clk);
    end
    if (!keep_start) start = 1'b0;
    n_vec++;
    if ({busy, done, sel_out, table_out} !== {1'b0, 1'b1, 3'd0, exp_tab}) begin
      n_err++;
      $display("FAIL %s done_cycle: busy/done/sel/table got %b/%b/%0d/%h want 0/1/0/%h",
               name, busy, done, sel_out, table_out, exp_tab);
    end
`ifdef SWEEP_CHECK_EN
    n_vec++;
    if (mismatch !== (exp_tab != exp_in)) begin
      n_err++;
      $display("FAIL %s mismatch: got %b want %b", name, mismatch, (exp_tab != exp_in));
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; f_mode = 0;
`ifdef SWEEP_CHECK_EN
    exp_in = 8'hBB;
`endif
    #1;
    n_vec++;
    if ({busy, done, sel_out, table_out} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_idle: busy/done/sel/table got %b/%b/%0d/%h want 0/0/0/00",
               busy, done, sel_out, table_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    f_mode = 0;
    do_sweep("func_bb", 8'hBB, 0, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({busy, done, table_out} !== {1'b0, 1'b0, 8'hBB}) begin
      n_err++;
      $display("FAIL func_hold: busy/done/table got %b/%b/%h want 0/0/bb", busy, done, table_out);
    end
  endtask

  task automatic test_constant;
    f_mode = 1;
    do_sweep("const0", 8'h00, 0, 1'b0);
    @(negedge clk);
    f_mode = 2;
    do_sweep("const1", 8'hFF, 0, 1'b0);
    @(negedge clk);
    f_mode = 0;
  endtask

  task automatic test_handshake;
    f_mode = 0;
    do_sweep("restart_ignored", 8'hBB, 5, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit seen;
    f_mode = 0;
    do_sweep("b2b_first", 8'hBB, 0, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({busy, done, table_out} !== {1'b0, 1'b0, 8'hBB}) begin
      n_err++;
      $display("FAIL b2b_idle_gap: busy/done/table got %b/%b/%h want 0/0/bb", busy, done, table_out);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, sel_out, table_out} !== {1'b1, 3'd0, 8'h00}) begin
      n_err++;
      $display("FAIL b2b_accept: busy/sel/table got %b/%0d/%h want 1/0/00", busy, sel_out, table_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (!seen || table_out !== 8'hBB) begin
      n_err++;
      $display("FAIL b2b_second: done_seen %b table %h want 1/bb", seen, table_out);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    f_mode = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, sel_out, table_out} !== 13'd0) begin
      n_err++;
      $display("FAIL abort_reset: busy/done/sel/table got %b/%b/%0d/%h want 0/0/0/00",
               busy, done, sel_out, table_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_sweep("after_abort", 8'hBB, 0, 1'b0);
    @(negedge clk);
  endtask

`ifdef SWEEP_CHECK_EN
  task automatic test_check;
    f_mode = 0;
    exp_in = 8'hBB;
    do_sweep("check_match", 8'hBB, 0, 1'b0);
    @(negedge clk);
    exp_in = 8'hBA;
    do_sweep("check_miss", 8'hBB, 0, 1'b0);
    exp_in = 8'hBB;
    repeat (4) @(negedge clk);
    n_vec++;
    if (mismatch !== 1'b1) begin
      n_err++;
      $display("FAIL mismatch_hold: got %b want 1", mismatch);
    end
    do_sweep("check_rearm", 8'hBB, 0, 1'b0);
    @(negedge clk);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_sweep;
    test_constant;
    test_handshake;
    test_back_to_back;
    test_abort;
`ifdef SWEEP_CHECK_EN
    test_check;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
